serial_sub: RTL

SERIAL_SUB -- requirements
Module: serial_sub

---
 rtl/serial_sub_if.sv | 46 ++++
 rtl/serial_sub.sv | 137 +++++++++++++
 2 files changed

// File: rtl/serial_sub_if.sv
// serial_sub_if -- operand/result bundle for the bit-serial subtractor.
//
// Handshake: the master drives start with a/b valid in the same cycle; the
// request is taken at a rising edge only when busy is low (slave in IDLE).
// While busy is high start is ignored. done pulses for one cycle when
// out/borrow/zero (and ovf when SERIAL_SUB_OVF_EN is defined) carry a new
// result; those outputs then hold until the next done.
//
// Signals:
//   start      master->slave  request to load operands
//   a, b       master->slave  minuend / subtrahend (WIDTH bits, unsigned)
//   busy       slave->master  operation in progress
//   done       slave->master  one-cycle result-valid pulse
//   out        slave->master  a-b modulo 2^WIDTH
//   borrow     slave->master  high iff a < b
//   zero       slave->master  high iff out == 0
//   ovf        slave->master  signed overflow (only with SERIAL_SUB_OVF_EN)
//   dbg_state  slave->master  FSM state for observation (0 IDLE,1 SHIFT,2 DONE)
interface serial_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             borrow;
  logic             zero;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif
  logic [1:0]       dbg_state;

`ifdef SERIAL_SUB_OVF_EN
  modport master (output start, a, b,
                  input  busy, done, out, borrow, zero, ovf, dbg_state);
  modport slave  (input  start, a, b,
                  output busy, done, out, borrow, zero, ovf, dbg_state);
`else
  modport master (output start, a, b,
                  input  busy, done, out, borrow, zero, dbg_state);
  modport slave  (input  start, a, b,
                  output busy, done, out, borrow, zero, dbg_state);
`endif
endinterface

// File: rtl/serial_sub.sv
// serial_sub -- bit-serial unsigned subtractor, one bit per clock, LSB first.
//
// Optional feature macro: SERIAL_SUB_OVF_EN adds the two's-complement
// overflow flag (bus.ovf); without it the flag and its logic are absent.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (aborts any operation, clears outputs)
//   bus   serial_sub_if.slave: start/a/b in, busy/done/out/borrow/zero[/ovf]
//         and dbg_state out
//
// Timing: start taken at the edge ending cycle t -> WIDTH SHIFT cycles
// (t+1 .. t+WIDTH) -> DONE in cycle t+WIDTH+1 with done high, then IDLE.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  serial_sub_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_out;
  logic             r_borrow;
  logic             r_zero;
`ifdef SERIAL_SUB_OVF_EN
  // Operand MSBs are kept aside because the shift registers lose them.
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_ovf;
`endif

  // One full-subtractor slice on the current LSBs.
  logic             w_diff;
  logic             w_br_next;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  assign w_diff     = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_next  = (~r_a[0] & r_b[0]) | (~r_a[0] & r_br) | (r_b[0] & r_br);
  assign w_res_next = {w_diff, r_res[WIDTH-1:1]};
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_out    <= '0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb <= bus.a[WIDTH-1];
            r_b_msb <= bus.b[WIDTH-1];
`endif
          end
        end
        S_SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br_next;
          r_res <= w_res_next;
          r_cnt <= r_cnt + CNT_W'(1);
          // Visible outputs are written only here, so they stay put through
          // every later SHIFT phase until the next result lands.
          if (w_last) begin
            r_out    <= w_res_next;
            r_borrow <= w_br_next;
            r_zero   <= (w_res_next == '0);
`ifdef SERIAL_SUB_OVF_EN
            r_ovf    <= (r_a_msb != r_b_msb) && (w_diff != r_a_msb);
`endif
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.out       = r_out;
  assign bus.borrow    = r_borrow;
  assign bus.zero      = r_zero;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf       = r_ovf;
`endif
  assign bus.dbg_state = r_state;

endmodule
